// File: rtl/ysyx_24110015_exu_pkg.sv
// Shared definitions for the M-extension execution unit: op encodings, FSM states and the
// signed-minimum helper.
package ysyx_24110015_exu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_e;

    // Most negative signed value of an xlen-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] int_min(input int unsigned xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/ysyx_24110015_div_step.sv
// Combinational restoring-division slice: retires STEP_BITS quotient bits per call.
module ysyx_24110015_div_step #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic [XLEN-1:0]      rem_in,
    input  logic [STEP_BITS-1:0] dvd_bits,
    input  logic [XLEN-1:0]      divisor,
    output logic [XLEN-1:0]      rem_out,
    output logic [STEP_BITS-1:0] q_bits
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] r;

    always_comb begin
        trial  = '0;
        r      = rem_in;
        q_bits = '0;
        for (int i = int'(STEP_BITS) - 1; i >= 0; i--) begin
            trial = {r, dvd_bits[i]};
            if (trial >= {1'b0, divisor}) begin
                trial     = trial - {1'b0, divisor};
                q_bits[i] = 1'b1;
            end
            // After a successful subtract the remainder is below the divisor, so it fits XLEN.
            r = trial[XLEN-1:0];
        end
        rem_out = r;
    end

endmodule

// File: rtl/ysyx_24110015_exu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Define YSYX_24110015_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module ysyx_24110015_exu_muldiv
    import ysyx_24110015_exu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_i,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    output logic            busy
);

    localparam int unsigned ITER = XLEN / STEP_BITS;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [63:0] INT_MIN_W = int_min(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = INT_MIN_W[XLEN-1:0];

    muldiv_state_e     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    // Operand conditioning on the request side
    logic            sgn1, sgn2, s1neg, s2neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, spec_res;

    always_comb begin
        sgn1     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        sgn2     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        s1neg    = sgn1 && src1[XLEN-1];
        s2neg    = sgn2 && src2[XLEN-1];
        mag1     = s1neg ? -src1 : src1;
        mag2     = s2neg ? -src2 : src2;
        div_zero = (src2 == '0);
        div_ovf  = !op[0] && (src1 == INT_MIN) && (src2 == '1);
        if (div_zero) spec_res = op[1] ? src1 : '1;
        else          spec_res = op[1] ? '0 : src1;
    end

`ifdef YSYX_24110015_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_raw, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_raw  = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_prod = (s1neg ^ s2neg) ? -fast_raw : fast_raw;
        fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Shift-add: acc = {partial product, remaining multiplier bits}
    logic [XLEN+STEP_BITS-1:0]   mul_sum;
    logic [2*XLEN+STEP_BITS-1:0] mul_wide;
    logic [2*XLEN-1:0]           mul_next;

    always_comb begin
        mul_sum  = {{STEP_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                 + {{STEP_BITS{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[STEP_BITS-1:0]};
        mul_wide = {mul_sum, acc_q[XLEN-1:0]} >> STEP_BITS;
        mul_next = mul_wide[2*XLEN-1:0];
    end

    // Restoring division: acc = {partial remainder, dividend bits shifting into quotient}
    logic [XLEN-1:0]      step_rem;
    logic [STEP_BITS-1:0] step_q;
    logic [XLEN-1:0]      div_lo;
    logic [2*XLEN-1:0]    div_next;

    ysyx_24110015_div_step #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_div_step (
        .rem_in   (acc_q[2*XLEN-1:XLEN]),
        .dvd_bits (acc_q[XLEN-1 -: STEP_BITS]),
        .divisor  (opnd_q),
        .rem_out  (step_rem),
        .q_bits   (step_q)
    );

    always_comb begin
        div_lo                = acc_q[XLEN-1:0] << STEP_BITS;
        div_lo[STEP_BITS-1:0] = step_q;
        div_next              = {step_rem, div_lo};
    end

    // Sign fixup applied as the last iteration lands in DONE
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -mul_next : mul_next;
        quo_fix  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_fix  = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    assign in_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        neg_rem_d   = neg_rem_q;
        rd_d        = rd_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d      = op;
                    rd_d      = rd_i;
                    neg_d     = s1neg ^ s2neg;
                    neg_rem_d = s1neg;
                    cnt_d     = '0;
                    if (op[2]) begin
                        if (div_zero || div_ovf) begin
                            result_d    = spec_res;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            opnd_d  = mag2;
                            acc_d   = {{XLEN{1'b0}}, mag1};
                            state_d = DIV;
                        end
                    end else begin
`ifdef YSYX_24110015_FAST_MUL_EN
                        result_d    = fast_res;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
`else
                        opnd_d  = mag1;
                        acc_d   = {{XLEN{1'b0}}, mag2};
                        state_d = MUL;
`endif
                    end
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    result_d    = fix_res;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            opnd_q      <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_o      = rd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_24110015_exu_muldiv.sv
// Directed bench for ysyx_24110015_exu_muldiv (XLEN=32, STEP_BITS=1, default build).
module tb_ysyx_24110015_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] src1, src2, result;
    logic [4:0]  rd_i, rd_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_24110015_exu_muldiv #(
        .XLEN      (32),
        .STEP_BITS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_i      (rd_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_o      (rd_o),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat counts posedges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, output int lat);
        @(negedge clk);
        check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b; rd_i = rd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "/ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat);
        int lat;
        run_op(tag, o, a, b, rd, lat);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, result, exp);
        check({tag, "/rd_o"}, {27'd0, rd_o}, {27'd0, rd});
        consume(tag);
    endtask

    initial begin
        int lat;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; op = 3'b000; src1 = '0; src2 = '0; rd_i = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/result", result, 32'd0);
        check("rst/rd_o", {27'd0, rd_o}, 32'd0);
        check("rst/busy", {31'd0, busy}, 32'd0);
        check("rst/in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle/in_ready", {31'd0, in_ready}, 32'd1);

        // Multiplies
        do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33);
        do_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 33);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFF, 33);

        // Special-case divides
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1);
        do_op("divu_z",  3'b101, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1);
        do_op("remu_z",  3'b111, 32'd5,         32'd0,         5'd10, 32'd5,         1);

        // Iterative divides
        do_op("rem_sgn", 3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, 33);
        do_op("rem_pos", 3'b110, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1,         33);
        do_op("divu",    3'b101, 32'd100,       32'd7,         5'd14, 32'd14,        33);
        do_op("remu",    3'b111, 32'd100,       32'd7,         5'd15, 32'd2,         33);
        do_op("divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1,        5'd16, 32'hFFFF_FFFF, 33);

        // Signed DIV under backpressure
        run_op("div_sgn", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, lat);
        check("div_sgn/latency", 32'(lat), 32'd33);
        check("div_sgn/result", result, 32'hFFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp/result", result, 32'hFFFF_FFFD);
            check("bp/out_valid", {31'd0, out_valid}, 32'd1);
            check("bp/in_ready", {31'd0, in_ready}, 32'd0);
        end
        consume("bp");

        // Flush mid-DIV: nothing ever comes out
        @(negedge clk);
        in_valid = 1'b1; op = 3'b101; src1 = 32'd100; src2 = 32'd7; rd_i = 5'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush/busy", {31'd0, busy}, 32'd0);
        check("flush/in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush/no_valid", {31'd0, seen}, 32'd0);
        do_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 33);

        // Flush together with acceptance discards the request
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'b000; src1 = 32'd3; src2 = 32'd3; rd_i = 5'd22;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_acc/busy", {31'd0, busy}, 32'd0);

        // Reset mid-MUL clears everything
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; src1 = 32'd3; src2 = 32'd5; rd_i = 5'd23;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid/result", result, 32'd0);
        check("rst_mid/rd_o", {27'd0, rd_o}, 32'd0);
        check("rst_mid/busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid/in_ready", {31'd0, in_ready}, 32'd1);
        do_op("post_rst", 3'b000, 32'd3, 32'd5, 5'd24, 32'd15, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
